// File: rtl/display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Shared constants and types for the 4-digit multiplexed display feeder.
//   DIGITS      : number of display digits
//   BCD_MAX     : largest value that can be shown in decimal
//   OVF_CODE    : decoder code used for the overflow pattern
//   AN_OFF      : anode pattern with every digit dark (active-low)
//   OVF_DISPLAY : display register contents for an out-of-range value
//   conv_state_e: converter FSM state encoding
//   bcd_adjust  : double-dabble "add 3 if >= 5" nibble correction
// ---------------------------------------------------------------------------
package display_pkg;

   localparam int          DIGITS      = 4;
   localparam int          BCD_MAX     = 9999;
   localparam logic [3:0]  OVF_CODE    = 4'hF;
   localparam logic [3:0]  AN_OFF      = 4'b1111;
   localparam logic [15:0] OVF_DISPLAY = {OVF_CODE, OVF_CODE, OVF_CODE, OVF_CODE};

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      CONVERT = 1'b1
   } conv_state_e;

   // A BCD nibble of 5 or more would overflow past 9 when doubled; adding 3
   // first makes the following shift carry into the next decade correctly.
   function automatic logic [3:0] bcd_adjust(input logic [3:0] nib);
      logic [3:0] res;
      if (nib >= 4'd5) begin
         res = nib + 4'd3;
      end else begin
         res = nib;
      end
      return res;
   endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential double-dabble binary-to-BCD engine, one iteration per clock.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : begin a conversion of bin_in (honoured only when idle)
//   bin_in    : unsigned binary operand, BIN_W bits
//   busy      : high while iterations are running (exactly BIN_W cycles)
//   done      : high during the final iteration cycle
//   bcd       : four BCD digits; valid while done is high, and equal to the
//               value the accumulator takes on that same clock edge
// ---------------------------------------------------------------------------
module bin_to_bcd_seq #(
   parameter int BIN_W = 14
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [BIN_W-1:0] bin_in,
   output logic             busy,
   output logic             done,
   output logic [15:0]      bcd
);

   import display_pkg::*;

   localparam int                CNT_W     = $clog2(BIN_W + 1);
   localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(BIN_W - 1);

   conv_state_e      state_q, state_d;
   logic [BIN_W-1:0] bin_q, bin_d;
   logic [15:0]      bcd_q, bcd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      adj_s;
   logic             done_s;

   // Next-state logic: load on start, then adjust-and-shift once per cycle.
   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      done_s  = 1'b0;
      adj_s   = bcd_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               bin_d   = bin_in;
               bcd_d   = 16'h0000;
               cnt_d   = {CNT_W{1'b0}};
               state_d = CONVERT;
            end else begin
               state_d = IDLE;
            end
         end
         CONVERT: begin
            for (int i = 0; i < DIGITS; i++) begin
               adj_s[i*4 +: 4] = bcd_adjust(bcd_q[i*4 +: 4]);
            end
            {bcd_d, bin_d} = {adj_s, bin_q} << 1;
            cnt_d          = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_ITER) begin
               done_s  = 1'b1;
               state_d = IDLE;
            end else begin
               state_d = CONVERT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Converter state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         bin_q   <= {BIN_W{1'b0}};
         bcd_q   <= 16'h0000;
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy = (state_q == CONVERT);
   assign done = done_s;
   assign bcd  = bcd_d;

endmodule

// File: rtl/display_scan.sv
// ---------------------------------------------------------------------------
// display_scan
// Feeds a 7-segment decoder for a 4-digit multiplexed display. A binary value
// captured on load is converted to BCD in the background; the shown value is
// only replaced once the conversion completes. Values above 9999 show "FFFF".
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   load      : single-cycle strobe, ignored while busy
//   value     : unsigned binary value to display (BIN_W bits)
//   blank_lz  : 1 = dark leading zero digits
//   busy      : conversion in progress
//   number    : digit code for the decoder (0-9 or 4'hF), registered
//   an        : active-low anode enables, an[0] = units digit, registered
// ---------------------------------------------------------------------------
module display_scan #(
   parameter int PRESCALE = 50000,
   parameter int BIN_W    = 14
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [BIN_W-1:0] value,
   input  logic             blank_lz,
   output logic             busy,
   output logic [3:0]       number,
   output logic [3:0]       an
);

   import display_pkg::*;

   localparam int             PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   logic            busy_s, done_s, start_s, ovf_s, load_ok_s, in_range_s;
   logic [15:0]     bcd_s;
   logic [15:0]     disp_q, disp_d;
   logic [PS_W-1:0] presc_q, presc_d;
   logic [1:0]      idx_q, idx_d;
   logic [3:0]      number_q, number_d;
   logic [3:0]      an_q, an_d;
   logic [3:0]      lead_zero_s, blank_s;
   logic            wrap_s;

   // Load qualification: in-range values start the converter, others
   // overwrite the display with the overflow pattern directly.
   always_comb begin
      load_ok_s  = load & ~busy_s;
      in_range_s = (32'(value) <= 32'(BCD_MAX));
      if (load_ok_s) begin
         start_s = in_range_s;
         ovf_s   = ~in_range_s;
      end else begin
         start_s = 1'b0;
         ovf_s   = 1'b0;
      end
   end

   bin_to_bcd_seq #(
      .BIN_W (BIN_W)
   ) u_conv (
      .clk    (clk),
      .rst    (rst),
      .start  (start_s),
      .bin_in (value),
      .busy   (busy_s),
      .done   (done_s),
      .bcd    (bcd_s)
   );

   // Display register: replaced only by a finished conversion or overflow.
   always_comb begin
      disp_d = disp_q;
      if (done_s) begin
         disp_d = bcd_s;
      end else if (ovf_s) begin
         disp_d = OVF_DISPLAY;
      end else begin
         disp_d = disp_q;
      end
   end

   // Scan timing: prescaler wraps every PRESCALE cycles, stepping the digit.
   always_comb begin
      wrap_s = (presc_q == PS_LAST);
      if (wrap_s) begin
         presc_d = {PS_W{1'b0}};
         idx_d   = idx_q + 2'd1;
      end else begin
         presc_d = presc_q + PS_W'(1);
         idx_d   = idx_q;
      end
   end

   // Leading-zero detection: a digit is a leading zero when it and every
   // higher digit are zero. The units digit always stays lit.
   always_comb begin
      lead_zero_s[3] = (disp_q[15:12] == 4'h0);
      lead_zero_s[2] = lead_zero_s[3] & (disp_q[11:8] == 4'h0);
      lead_zero_s[1] = lead_zero_s[2] & (disp_q[7:4]  == 4'h0);
      lead_zero_s[0] = 1'b0;
      if (blank_lz && (disp_q != OVF_DISPLAY)) begin
         blank_s = lead_zero_s;
      end else begin
         blank_s = 4'b0000;
      end
   end

   // Output stage inputs: digit code and anode for the current scan index.
   always_comb begin
      number_d = disp_q[{idx_q, 2'b00} +: 4];
      if (blank_s[idx_q]) begin
         an_d = AN_OFF;
      end else begin
         an_d = ~(4'b0001 << idx_q);
      end
   end

   // Display, scan and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         disp_q   <= 16'h0000;
         presc_q  <= {PS_W{1'b0}};
         idx_q    <= 2'd0;
         number_q <= 4'h0;
         an_q     <= AN_OFF;
      end else begin
         disp_q   <= disp_d;
         presc_q  <= presc_d;
         idx_q    <= idx_d;
         number_q <= number_d;
         an_q     <= an_d;
      end
   end

   assign busy   = busy_s;
   assign number = number_q;
   assign an     = an_q;

endmodule
